// File: rtl/fir_requant_q15.sv
// fir_requant_q15: rounds and saturates FIR accumulator samples to Q15 and buffers them in a show-ahead FIFO (optional sat_count via REQUANT_SAT_CNT_EN)
module fir_requant_q15 #(
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SH    = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             acc_in_valid,
  output logic [OUT_W-1:0] q_out,
  output logic             q_out_valid,
  input  logic             q_out_ready,
  output logic             overflow
`ifdef REQUANT_SAT_CNT_EN
  ,
  output logic [15:0]      sat_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(64'sd1 <<< (FRAC_SH-1));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;
  logic signed [ACC_W:0] sum, r;
  logic sat_hi, sat_lo;
  logic [OUT_W-1:0] q_sat, st_q;
  logic st_val, full, push, pop;
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  // round half-up one bit wider than the input so the bias add never wraps, then clamp to Q15
  always_comb begin
    sum    = $signed({acc_in[ACC_W-1], acc_in}) + HALF;
    r      = sum >>> FRAC_SH;
    sat_hi = r > MAXV;
    sat_lo = r < MINV;
    q_sat  = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} : sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : r[OUT_W-1:0];
  end
  // a full FIFO still accepts a push when the same edge pops
  always_comb begin
    q_out_valid = count != '0;
    full        = count == (AW+1)'(FIFO_DEPTH);
    pop         = q_out_valid && q_out_ready;
    push        = st_val && (!full || pop);
    q_out       = q_out_valid ? mem[rd_ptr] : '0;
  end
  // stage register, FIFO pointers/occupancy and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_val   <= 1'b0;
      st_q     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      st_val <= acc_in_valid;
      if (acc_in_valid) st_q <= q_sat;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (st_val && full && !pop) overflow <= 1'b1;
    end
  end
  // FIFO storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= st_q;
  end
`ifdef REQUANT_SAT_CNT_EN
  // saturating count of clamped samples entering the stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_count <= '0;
    else if (acc_in_valid && (sat_hi || sat_lo) && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fir_requant_q15.sv
// tb_fir_requant_q15: directed and random checks of fir_requant_q15 against a queue-based reference model
module tb_fir_requant_q15;
  logic clk = 1'b0;
  logic rst;
  logic [39:0] acc_in;
  logic acc_in_valid;
  logic [15:0] q_out;
  logic q_out_valid;
  logic q_out_ready;
  logic overflow;
`ifdef REQUANT_SAT_CNT_EN
  logic [15:0] sat_count;
`endif
  int checks = 0;
  int passes = 0;
  bit m_sv;
  logic [15:0] m_sq;
  logic [15:0] mq[$];
  bit m_ovf;
  int m_sat;

  fir_requant_q15 dut (
    .clk(clk),
    .rst(rst),
    .acc_in(acc_in),
    .acc_in_valid(acc_in_valid),
    .q_out(q_out),
    .q_out_valid(q_out_valid),
    .q_out_ready(q_out_ready),
    .overflow(overflow)
`ifdef REQUANT_SAT_CNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] requant(input logic [39:0] a, output bit sat);
    longint s, r;
    s = longint'($signed(a));
    r = (s + 64'sd16384) >>> 15;
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    if (r < -32768) begin r = -32768; sat = 1'b1; end
    return 16'(r);
  endfunction

  task automatic model_clear();
    m_sv = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_sat = 0;
  endtask

  task automatic cyc(input logic v, input logic [39:0] a, input logic rdy);
    bit s;
    acc_in = a;
    acc_in_valid = v;
    q_out_ready = rdy;
    @(posedge clk);
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (m_sv) begin
      if (mq.size() < 4) mq.push_back(m_sq);
      else m_ovf = 1'b1;
    end
    m_sv = v;
    if (v) begin
      m_sq = requant(a, s);
      if (s && m_sat < 65535) m_sat++;
    end
    #1;
    check("valid", 16'(q_out_valid), 16'(mq.size() > 0));
    if (mq.size() > 0) check("q_out", q_out, mq[0]);
    check("overflow", 16'(overflow), 16'(m_ovf));
`ifdef REQUANT_SAT_CNT_EN
    check("sat_count", sat_count, 16'(m_sat));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_valid", 16'(q_out_valid), 16'd0);
    check("rst_q", q_out, 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic one(input logic [39:0] a, input logic [15:0] exp, input int dsat);
`ifdef REQUANT_SAT_CNT_EN
    logic [15:0] s0 = sat_count;
`endif
    cyc(1'b1, a, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("single_q", q_out, exp);
`ifdef REQUANT_SAT_CNT_EN
    check("single_sat", sat_count, s0 + 16'(dsat));
`endif
    cyc(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [63:0] w;
    rst = 1'b1;
    acc_in = '0;
    acc_in_valid = 1'b0;
    q_out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 16'(q_out_valid), 16'd0);
    check("reset_q", q_out, 16'd0);
    check("reset_ovf", 16'(overflow), 16'd0);
`ifdef REQUANT_SAT_CNT_EN
    check("reset_sat", sat_count, 16'd0);
`endif
    rst = 1'b0;
    cyc(1'b1, 40'h0020000000, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("lat_valid", 16'(q_out_valid), 16'd1);
    check("lat_q", q_out, 16'h4000);
    cyc(1'b0, '0, 1'b1);
    check("one_cycle", 16'(q_out_valid), 16'd0);
    one(40'h0000004000, 16'h0001, 0);
    one(40'h0000003FFF, 16'h0000, 0);
    one(40'hFFFFFFC000, 16'h0000, 0);
    one(40'hFFFFFFBFFF, 16'hFFFF, 0);
    one(40'h0040000000, 16'h7FFF, 1);
    one(40'hFFC0000000, 16'h8000, 0);
    one(40'hFF80000000, 16'h8000, 1);
    for (int k = 1; k <= 6; k++) cyc(1'b1, 40'(k) << 15, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("drop_ovf", 16'(overflow), 16'd1);
    for (int k = 1; k <= 4; k++) begin
      check("drain_order", q_out, 16'(k));
      cyc(1'b0, '0, 1'b1);
    end
    check("drain_empty", 16'(q_out_valid), 16'd0);
    check("ovf_sticky", 16'(overflow), 16'd1);
    do_reset();
    for (int k = 1; k <= 5; k++) cyc(1'b1, 40'(k) << 15, 1'b0);
    for (int k = 6; k <= 17; k++) cyc(1'b1, 40'(k) << 15, 1'b1);
    check("stream_ovf", 16'(overflow), 16'd0);
    check("stream_full", 16'(mq.size()), 16'd4);
    do_reset();
    for (int k = 1; k <= 3; k++) cyc(1'b1, 40'(k) << 15, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("pre_rst_valid", 16'(q_out_valid), 16'd1);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("async_valid", 16'(q_out_valid), 16'd0);
    check("async_q", q_out, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, '0, 1'b1);
    check("post_rst_empty", 16'(q_out_valid), 16'd0);
    for (int i = 0; i < 400; i++) begin
      w = {$urandom(), $urandom()};
      cyc(1'($urandom_range(0, 3) != 0),
          w[40] ? w[39:0] : {{16{w[23]}}, w[23:0]},
          1'($urandom_range(0, 9) > (i < 200 ? 2 : 6)));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout observed=running expected=finished");
  end
endmodule

// File: doc/fir_requant_q15.md
FIR_REQUANT_Q15 -- requirements
Module: fir_requant_q15

Interface
REQ-001 Parameter ACC_W, 40, width of the signed accumulator input.
REQ-002 Parameter OUT_W, 16, width of the signed Q15 output.
REQ-003 Parameter FRAC_SH, 15, right-shift applied during requantisation.
REQ-004 Parameter FIFO_DEPTH, 4, output FIFO entries; must be a power of two and at least 2.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 acc_in  input  ACC_W  signed accumulator sample from the upstream pruned FIR.
REQ-008 acc_in_valid  input  1  acc_in is qualified this cycle; there is no backpressure to the FIR.
REQ-009 q_out  output  OUT_W  signed Q15 sample at the FIFO head.
REQ-010 q_out_valid  output  1  FIFO is non-empty and q_out is valid.
REQ-011 q_out_ready  input  1  consumer accepts q_out when q_out_valid and q_out_ready are both high.
REQ-012 overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.
REQ-013 sat_count  output  16  number of accepted samples that saturated (present only with REQUANT_SAT_CNT_EN).

Function
REQ-014 Rounding: r = (acc_in + 2^(FRAC_SH-1)) >>> FRAC_SH, computed at ACC_W+1 bits so the add cannot wrap; this is round-half-up.
REQ-015 Saturation: r > 2^(OUT_W-1)-1 gives 0x7FFF and r < -2^(OUT_W-1) gives 0x8000; either case is a saturation event.
REQ-016 Stage register: when acc_in_valid is high, the rounded and saturated value and its valid bit are registered at that edge (edge k).
REQ-017 Push: at edge k+1 the stage value is written into the FIFO, so q_out_valid rises after edge k+1 when the FIFO was empty (2-cycle latency).
REQ-018 The FIFO is show-ahead: q_out always presents the oldest entry, and a pop occurs on any edge where q_out_valid and q_out_ready are both high.
REQ-019 Simultaneous push and pop: allowed at any occupancy, including full; count is unchanged and ordering is preserved.
REQ-020 Full and no pop: a push is discarded, the FIFO contents are unchanged, and overflow is set at that edge.
REQ-021 Empty: q_out_valid is 0, q_out_ready is ignored, and the count never underflows.
REQ-022 Read and write pointers wrap modulo FIFO_DEPTH; the count ranges from 0 to FIFO_DEPTH.
REQ-023 acc_in_valid may be high on consecutive cycles; one sample per cycle is sustained whenever q_out_ready is held high.
REQ-024 q_out holds a stable value while q_out_valid is high and q_out_ready is low.

Reset
REQ-025 Asserting rst clears the stage valid bit, the pointers, the count, overflow and sat_count immediately, regardless of clk.
REQ-026 During reset, q_out_valid=0, q_out=0, overflow=0 and sat_count=0; any in-flight or queued samples are discarded.
REQ-027 The first acc_in_valid sampled on the first rising edge after rst deasserts is processed normally.
REQ-028 overflow is cleared only by rst.

Configuration
REQ-029 Macro REQUANT_SAT_CNT_EN defined: sat_count exists and increments by 1 for each saturation event in the stage register, holding at 0xFFFF.
REQ-030 Macro REQUANT_SAT_CNT_EN undefined: the sat_count port and its counter are absent, and all other behaviour is identical.

Verification
REQ-031 acc_in=0x0020000000 (one pulse), q_out_ready=1 -> q_out=0x4000 with q_out_valid high after the second edge, for exactly 1 cycle.
REQ-032 Rounding: acc_in=0x0000004000 gives 1; 0x0000003FFF gives 0; 0xFFFFFFC000 gives 0; 0xFFFFFFBFFF gives -1 (0xFFFF).
REQ-033 Saturation: 0x0040000000 gives 0x7FFF (sat_count +1); 0xFFC0000000 gives 0x8000 (no count); 0xFF80000000 gives 0x8000 (sat_count +1).
REQ-034 q_out_ready=0, 6 consecutive valid samples 1..6 -> FIFO holds 1..4, samples 5 and 6 are dropped, and overflow=1; raising ready then yields 1,2,3,4 in order.
REQ-035 FIFO full with continuous input and q_out_ready=1 -> one pop and one push per cycle, no drop, and overflow stays 0.
REQ-036 rst asserted mid-burst with 3 entries queued -> q_out_valid drops to 0 asynchronously, and the count is 0 after release.
